psum_accum_buffer: RTL
======================

Name: psum_accum_buffer

Overview:
- Partial-sum buffer directly downstream of PE_array; closes the accumulation loop around it.
- Stores one 4-lane entry of 16-bit partial sums per output position and drives psum1..psum4 into PE_array.
- Captures out1..out4 after the fixed PE latency and writes them back, once per position per pass.
- After the last pass, streams the finished entries to the output writer over a valid/ready interface.

Parameters:
DEPTH, 16, number of output positions stored (entries of 4x16 bit)
AW, 4, address width, clog2(DEPTH)
PE_LAT, 2, cycles from pe_valid/psum presentation to matching out1..out4

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a job (sampled only in IDLE)
num_pos  in  AW+1  positions per pass, 1..DEPTH, sampled on start
num_pass  in  8  accumulation passes, 1..255, sampled on start
busy  out  1  high from cycle after accepted start until done pulse
pe_valid  out  1  psum1..4 valid this cycle (issue cycle)
psum1..psum4  out  16 each  partial sums to PE_array lanes 1..4
out1..out4  in  16 each  PE_array results, valid PE_LAT cycles after issue
dout_valid  out  1  drain entry valid
dout_ready  in  1  downstream accepts entry
dout  out  64  {lane4,lane3,lane2,lane1} of drained entry
dout_last  out  1  high with final drained entry
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: state IDLE. busy, pe_valid, dout_valid, dout_last and done = 0. psum1..4 = 0, dout = 0. Latency delay line cleared. Storage contents undefined, never read before written.
- rst asserted mid-job: abandons the job in the next cycle. Pending write-backs are discarded.
- IDLE: start=1 latches num_pos (clamped to DEPTH if larger) and num_pass, and goes to ISSUE. start in any other state is ignored.
  - If num_pos==0 or num_pass==0: skip to DONE. No issue, no drain.
- ISSUE:
  - Each cycle drives pe_valid=1 with rd_addr = 0..num_pos-1, in order.
  - Pass 0: psum1..4 = 16'h0000 (no memory read).
  - Later passes: psum_k = mem[rd_addr].lane_k.
  - psum outputs are registered and change only with pe_valid.
  - pe_valid is low on all non-issue cycles; psum values then hold their last value.
- Write-back: an internal PE_LAT-deep shift register carries {valid, addr}. When its tail is valid, mem[addr] <= {out4,out3,out2,out1} at the end of that cycle.
  - Applies on every pass, including the last.
  - No saturation or arithmetic in this block; values are stored bit-exact.
- Hazard rule: the issue of address a in pass p+1 occurs no earlier than PE_LAT+1 cycles after its issue in pass p.
  - When num_pos < PE_LAT+1, the FSM inserts (PE_LAT+1-num_pos) bubble cycles (pe_valid=0) at each pass boundary.
  - When num_pos >= PE_LAT+1, passes issue back-to-back with no bubble.
- After the last issue of the last pass: go to FLUSH and wait PE_LAT cycles until the delay line is empty, then go to DRAIN.
- DRAIN:
  - Address counter from 0. dout = mem[addr]; dout_valid=1.
  - Transfer occurs when dout_valid && dout_ready; addr advances after each transfer.
  - dout_last=1 when addr==num_pos-1.
  - dout and dout_valid are stable while dout_ready=0.
  - After the last transfer, go to DONE.
- DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
  - A start in the cycle after DONE is accepted.
- busy=1 in ISSUE, FLUSH and DRAIN.
- No back-pressure to PE_array; out1..4 are consumed unconditionally at their fixed latency.

Test Plan:
- Bench PE model: out_k = psum_k + k, PE_LAT=2. num_pos=4, num_pass=3, dout_ready=1 -> 4 drained entries, each lanes {12,9,6,3}. dout_last on the 4th. done exactly 1 cycle after the last transfer.
- num_pos=1, num_pass=4 -> 2 bubble cycles between issues (issue period 3). Drained entry {16,12,8,4}. pe_valid never reads a stale entry (checker: psum equals previous pass out).
- Drain back-pressure: num_pos=3, num_pass=1, dout_ready toggling 1,0,0,1,0,1 -> 3 transfers with values {4,3,2,1}. dout held stable during ready=0 cycles. dout_last only on the 3rd transfer.
- start with num_pass=0 -> done pulse 1 cycle later, pe_valid and dout_valid never assert. Also start during ISSUE: ignored, job results unchanged.
- rst asserted for 1 cycle mid-ISSUE of pass 1 -> next cycle all outputs 0 and state IDLE. A new job num_pos=2, num_pass=1 drains {4,3,2,1} twice.
- num_pos=20 with DEPTH=16 -> clamped. Exactly 16 issues per pass and 16 drained entries.

Source files
------------

// File: rtl/psum_accum_buffer.sv
// Partial-sum buffer that closes the accumulation loop around PE_array:
// issues stored psums, writes back PE results after PE_LAT, then drains finished entries.
module psum_accum_buffer #(
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int PE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   num_pos,
  input  logic [7:0]    num_pass,
  output logic          busy,
  output logic          pe_valid,
  output logic [15:0]   psum1,
  output logic [15:0]   psum2,
  output logic [15:0]   psum3,
  output logic [15:0]   psum4,
  input  logic [15:0]   out1,
  input  logic [15:0]   out2,
  input  logic [15:0]   out3,
  input  logic [15:0]   out4,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [63:0]   dout,
  output logic          dout_last,
  output logic          done
);
  localparam int DATA_W = 16;
  localparam int ENT_W  = 4 * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUBBLE, S_FLUSH, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [AW:0]       np_m1, np_clamp, bub_cnt;
  logic [7:0]        npass_m1, pass_cnt;
  logic [AW-1:0]     rd_addr, dr_addr, dr_nxt, addr_p0;
  logic [PE_LAT-1:0] wb_vld_pn;
  logic [AW-1:0]     wb_addr_pn [PE_LAT];
  logic [ENT_W-1:0]  pe_out, rd_data;
  logic              fire, last_pos, last_pass, short_pass, pipe_empty, xfer, dr_last, wb_vld;
  logic [AW-1:0]     wb_addr;

  always_comb begin
    np_clamp   = (num_pos > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_pos;
    fire       = (state == S_ISSUE);
    last_pos   = ({1'b0, rd_addr} == np_m1);
    last_pass  = (pass_cnt == npass_m1);
    short_pass = (np_m1 < (AW+1)'(PE_LAT));
    wb_vld     = wb_vld_pn[PE_LAT-1];
    wb_addr    = wb_addr_pn[PE_LAT-1];
    pe_out     = {out4, out3, out2, out1};
    // Forward the result being written this cycle so a tight re-issue never sees stale data
    rd_data    = (wb_vld && (wb_addr == rd_addr)) ? pe_out : mem[rd_addr];
    pipe_empty = !pe_valid && (wb_vld_pn == '0);
    xfer       = (state == S_DRAIN) && dout_valid && dout_ready;
    dr_last    = ({1'b0, dr_addr} == np_m1);
    dr_nxt     = dr_addr + AW'(1);
    busy       = (state == S_ISSUE) || (state == S_BUBBLE) || (state == S_FLUSH) || (state == S_DRAIN);
    done       = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = ((num_pos == '0) || (num_pass == '0)) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (last_pos) state_nxt = last_pass ? S_FLUSH : (short_pass ? S_BUBBLE : S_ISSUE);
      S_BUBBLE: if (bub_cnt == (AW+1)'(1)) state_nxt = S_ISSUE;
      S_FLUSH:  if (pipe_empty) state_nxt = S_DRAIN;
      S_DRAIN:  if (xfer && dr_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control: job counters, issue stage p0, drain handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      np_m1      <= '0;
      npass_m1   <= '0;
      pass_cnt   <= '0;
      rd_addr    <= '0;
      bub_cnt    <= '0;
      dr_addr    <= '0;
      pe_valid   <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      psum1      <= '0;
      psum2      <= '0;
      psum3      <= '0;
      psum4      <= '0;
      dout       <= '0;
    end else begin
      pe_valid <= fire;
      if (fire) begin
        if (pass_cnt == '0) {psum4, psum3, psum2, psum1} <= '0;
        else                {psum4, psum3, psum2, psum1} <= rd_data;
      end
      case (state)
        S_IDLE: if (start) begin
          np_m1    <= np_clamp - (AW+1)'(1);
          npass_m1 <= num_pass - 8'd1;
          pass_cnt <= '0;
          rd_addr  <= '0;
        end
        S_ISSUE: begin
          if (last_pos) begin
            rd_addr  <= '0;
            pass_cnt <= pass_cnt + 8'd1;
            bub_cnt  <= (AW+1)'(PE_LAT) - np_m1;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        S_BUBBLE: bub_cnt <= bub_cnt - (AW+1)'(1);
        S_FLUSH: if (pipe_empty) begin
          dr_addr    <= '0;
          dout       <= mem[0];
          dout_valid <= 1'b1;
          dout_last  <= (np_m1 == '0);
        end
        S_DRAIN: if (xfer) begin
          if (dr_last) begin
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end else begin
            dr_addr   <= dr_nxt;
            dout      <= mem[dr_nxt];
            dout_last <= ({1'b0, dr_nxt} == np_m1);
          end
        end
        default: ;
      endcase
    end
  end

  // Write-back delay line p1..pN: {valid, addr} follows the PE latency
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_pn <= '0;
    end else begin
      wb_vld_pn[0] <= pe_valid;
      for (int i = 1; i < PE_LAT; i++) wb_vld_pn[i] <= wb_vld_pn[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (fire) addr_p0 <= rd_addr;
    wb_addr_pn[0] <= addr_p0;
    for (int i = 1; i < PE_LAT; i++) wb_addr_pn[i] <= wb_addr_pn[i-1];
    if (wb_vld && !rst) mem[wb_addr] <= pe_out;
  end

endmodule
